fifo_write_logic: RTL and testbench
===================================

Name: fifo_write_logic

Overview:
- Write-domain control for the async FIFO; the upstream partner of the read-side pointer logic.
- Accepts writes, drives the dual-port RAM write port, and maintains binary and Gray write pointers.
- Synchronises the read-side Gray pointer into the write clock domain with a 2-flop synchroniser.
- Produces registered full, almost_full and fill-level outputs, plus a sticky overflow error.

Parameters:
- DATA_WIDTH, 8, width of write data.
- FIFO_DEPTH, 64, number of entries; must be a power of 2 and at least 4.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), RAM address width.
- PTR_WIDTH, ADDR_WIDTH+1, pointer width including the wrap bit.
- ALMOST_FULL_THRESH, FIFO_DEPTH-4, fill level at or above which almost_full asserts.

Ports:
- wr_clk  input  1  write-domain clock (the block's only clock).
- wr_rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  data to write.
- rd_ptr_gray  input  PTR_WIDTH  read pointer in Gray code, from the read clock domain.
- mem_we  output  1  RAM write enable.
- mem_waddr  output  ADDR_WIDTH  RAM write address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- wr_ptr  output  PTR_WIDTH  binary write pointer (registered).
- wr_ptr_gray  output  PTR_WIDTH  Gray write pointer (registered), for the read-domain synchroniser.
- full  output  1  FIFO full (registered).
- almost_full  output  1  fill level >= ALMOST_FULL_THRESH (registered).
- wr_level  output  PTR_WIDTH  fill level as seen from the write domain (registered).
- overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (asynchronous assert on wr_rst_n low, synchronous release):
  - wr_ptr, wr_ptr_gray, both synchroniser stages, wr_level = 0.
  - full, almost_full, overflow = 0.
  - mem_we = 0 while in reset.
- Write accept: accept = wr_en && !full.
- RAM port, combinational, zero latency:
  - mem_we = accept.
  - mem_waddr = wr_ptr[ADDR_WIDTH-1:0].
  - mem_wdata = wr_data.
  - RAM captures on the same wr_clk edge.
- Pointer update on accept:
  - wr_ptr_next = wr_ptr + 1, modulo 2^PTR_WIDTH; wraps naturally.
  - wr_ptr_gray registered as wr_ptr_next ^ (wr_ptr_next >> 1).
  - No accept: both pointers hold.
- Synchroniser: rd_ptr_gray passes through two wr_clk flops to give rq2; rq2 is converted to binary rd_bin_sync combinationally.
  - Pointer motion is visible to full/level 3 wr_clk edges after rd_ptr_gray changes: 2 synchroniser flops + 1 register stage for full/wr_level.
- Full, computed from the next-state pointer and registered:
  - full <= (gray(wr_ptr_next) == {~rq2[PTR_WIDTH-1:PTR_WIDTH-2], rq2[PTR_WIDTH-3:0]}).
  - Asserts on the same edge that accepts the FIFO_DEPTH-th entry.
  - Deasserts 3 edges after the read side frees a slot.
- Level and almost_full:
  - wr_level <= (wr_ptr_next - rd_bin_sync), modulo 2^PTR_WIDTH; range 0..FIFO_DEPTH.
  - almost_full <= (that value >= ALMOST_FULL_THRESH).
- Overflow:
  - On wr_en && full: no RAM write, pointer held, overflow <= 1.
  - Remains 1 until reset.
- Read-side lag is conservative: full and wr_level may overstate occupancy by up to the synchroniser lag, and never understate it.
- Simultaneous wr_en with read-side movement: the write is accepted using the current registered full. Reads are reflected later.
- Reset mid-burst: pointers return to 0 immediately (asynchronously); any in-flight write that cycle is discarded.

Test Plan:
- FIFO_DEPTH=8, ALMOST_FULL_THRESH=4, rd_ptr_gray held at 0; reset, then 8 consecutive writes of 0x10..0x17:
  - mem_waddr steps 0..7 with mem_we=1.
  - almost_full=1 after the 4th accept edge; full=1 after the 8th.
  - wr_ptr=8, wr_ptr_gray=0b1100, wr_level=8.
- While full, pulse wr_en for one cycle with data 0xAA -> mem_we=0, wr_ptr stays 8, overflow=1 and stays 1 through later activity.
- From full, set rd_ptr_gray=0b0001 (1 read):
  - full stays 1 for 2 edges, drops on the 3rd edge.
  - wr_level=7.
  - Next write goes to mem_waddr=0.
- Wrap: 16 writes interleaved with matching read-pointer advances -> wr_ptr passes 15->0, wr_ptr_gray 0b1000->0b0000, full never asserts, wr_level never exceeds 2.
- Assert wr_rst_n=0 mid-burst, asynchronously between edges -> all outputs return to 0 immediately, including overflow=0, with no wr_clk edge required.
- Random wr_en/read advance for 10k cycles against a scoreboard model -> no write accepted while full, and wr_level ≥ true occupancy every cycle.

Source files
------------

// File: rtl/fifo_write_logic.sv
// Write-domain control for the async FIFO: RAM write port, binary/Gray write
// pointers, read-pointer synchroniser, and registered full/level/overflow status.
module fifo_write_logic #(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned FIFO_DEPTH         = 64,
  parameter int unsigned ALMOST_FULL_THRESH = FIFO_DEPTH - 4,
  localparam int unsigned ADDR_WIDTH        = $clog2(FIFO_DEPTH),
  localparam int unsigned PTR_WIDTH         = ADDR_WIDTH + 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_WIDTH-1:0]  rd_ptr_gray,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [PTR_WIDTH-1:0]  wr_ptr,
  output logic [PTR_WIDTH-1:0]  wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [PTR_WIDTH-1:0]  wr_level,
  output logic                  overflow
);

  logic [PTR_WIDTH-1:0] rq1;
  logic [PTR_WIDTH-1:0] rq2;
  logic [PTR_WIDTH-1:0] rd_bin_sync;
  logic [PTR_WIDTH-1:0] wr_ptr_next;
  logic [PTR_WIDTH-1:0] wr_gray_next;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic [PTR_WIDTH-1:0] level_next;
  logic                 accept;
  logic                 full_next;
  logic                 almost_full_next;

  // RAM write port is combinational so the RAM captures on the accepting edge.
  assign accept    = wr_en && !full;
  assign mem_we    = accept && wr_rst_n;
  assign mem_waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign mem_wdata = wr_data;

  // Next-state pointers and status, evaluated against the synchronised read pointer.
  always_comb begin
    rd_bin_sync = '0;
    for (int i = 0; i < int'(PTR_WIDTH); i++) begin
      rd_bin_sync[i] = ^(rq2 >> i);
    end
    wr_ptr_next      = wr_ptr + PTR_WIDTH'(accept);
    wr_gray_next     = wr_ptr_next ^ (wr_ptr_next >> 1);
    full_cmp         = {~rq2[PTR_WIDTH-1:PTR_WIDTH-2], rq2[PTR_WIDTH-3:0]};
    full_next        = (wr_gray_next == full_cmp);
    level_next       = wr_ptr_next - rd_bin_sync;
    almost_full_next = (32'(level_next) >= ALMOST_FULL_THRESH);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      rq1         <= '0;
      rq2         <= '0;
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      rq1         <= rd_ptr_gray;
      rq2         <= rq1;
      wr_ptr      <= wr_ptr_next;
      wr_ptr_gray <= wr_gray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wr_level    <= level_next;
      // Sticky until reset: a write was dropped because the FIFO was full.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_logic.sv
// Bench for fifo_write_logic (depth 8, almost-full at 4): directed fill/overflow/
// drain/wrap/reset steps followed by random traffic against an occupancy model.
module tb_fifo_write_logic;

  logic       wr_clk;
  logic       wr_rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [3:0] rd_ptr_gray;
  logic       mem_we;
  logic [2:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] wr_ptr;
  logic [3:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic       overflow;

  fifo_write_logic #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(8),
    .ALMOST_FULL_THRESH(4)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst_n(wr_rst_n),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_ptr_gray(rd_ptr_gray),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .wr_ptr(wr_ptr),
    .wr_ptr_gray(wr_ptr_gray),
    .full(full),
    .almost_full(almost_full),
    .wr_level(wr_level),
    .overflow(overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: total entries accepted, reads as seen by the write side two cycles late.
  int wcount = 0;
  int rd_p1  = 0;
  int rd_p2  = 0;
  bit m_full = 0;
  bit m_ovf  = 0;
  int rd_cur = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic m_reset();
    wcount = 0;
    rd_p1  = 0;
    rd_p2  = 0;
    m_full = 0;
    m_ovf  = 0;
    rd_cur = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_ptr"}, 32'(wr_ptr), 0);
    chk({tag, "_gray"}, 32'(wr_ptr_gray), 0);
    chk({tag, "_level"}, 32'(wr_level), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_waddr"}, 32'(mem_waddr), 0);
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic we, input logic [7:0] d, input int rd);
    bit acc;
    int lvl;
    wr_en       = we;
    wr_data     = d;
    rd_ptr_gray = to_gray(rd);
    #2;
    acc = we && !m_full;
    chk("mem_we", 32'(mem_we), 32'(acc));
    chk("mem_waddr", 32'(mem_waddr), 32'(wcount % 8));
    chk("mem_wdata", 32'(mem_wdata), 32'(d));
    if (we && m_full) m_ovf = 1;
    if (acc) wcount++;
    lvl    = wcount - rd_p2;
    m_full = (lvl == 8);
    rd_p2  = rd_p1;
    rd_p1  = rd;
    @(posedge wr_clk);
    #1;
    chk("wr_ptr", 32'(wr_ptr), 32'(wcount % 16));
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(wcount)));
    chk("wr_level", 32'(wr_level), 32'(lvl));
    chk("full", 32'(full), 32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(lvl >= 4));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("level_ge_occ", 32'(int'(wr_level) >= wcount - rd), 1);
  endtask

  initial begin
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    rd_ptr_gray = 4'h0;
    wr_rst_n    = 1'b1;
    #1 wr_rst_n = 1'b0;
    #2 chk_all_zero("reset");
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    m_reset();

    // Fill all 8 entries with read pointer parked at 0.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 0);
    chk("fill_wr_ptr", 32'(wr_ptr), 8);
    chk("fill_gray", 32'(wr_ptr_gray), 32'b1100);
    chk("fill_level", 32'(wr_level), 8);
    chk("fill_full", 32'(full), 1);

    // Write while full is dropped and latches overflow.
    step(1'b1, 8'hAA, 0);
    chk("ovf_wr_ptr", 32'(wr_ptr), 8);
    chk("ovf_flag", 32'(overflow), 1);

    // One read frees a slot; full drops on the third edge.
    step(1'b0, 8'h00, 1);
    chk("drain_full_e1", 32'(full), 1);
    step(1'b0, 8'h00, 1);
    chk("drain_full_e2", 32'(full), 1);
    step(1'b0, 8'h00, 1);
    chk("drain_full_e3", 32'(full), 0);
    chk("drain_level", 32'(wr_level), 7);
    step(1'b1, 8'h55, 1);
    chk("refill_wr_ptr", 32'(wr_ptr), 9);
    chk("ovf_sticky", 32'(overflow), 1);

    // Asynchronous reset between edges, with a write in flight.
    wr_en   = 1'b1;
    wr_data = 8'h77;
    rd_ptr_gray = 4'h0;
    #2;
    wr_rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge wr_clk);
    #1 chk_all_zero("rst_hold");
    wr_rst_n = 1'b1;
    m_reset();

    // Wrap: writes interleaved with matching read advances.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), rd_cur);
      chk("wrap_lvl_w", 32'(wr_level <= 4'd2), 1);
      rd_cur = wcount;
      step(1'b0, 8'h00, rd_cur);
      chk("wrap_lvl_r", 32'(wr_level <= 4'd2), 1);
      chk("wrap_nofull", 32'(full), 0);
    end
    chk("wrap_wr_ptr", 32'(wr_ptr), 0);
    chk("wrap_gray", 32'(wr_ptr_gray), 0);

    // Random traffic with alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 10000; i++) begin
      logic we;
      if ((i / 500) % 2 == 0) begin
        we = ($urandom_range(0, 3) != 0);
        if (rd_cur < wcount && $urandom_range(0, 2) == 0) rd_cur++;
      end else begin
        we = ($urandom_range(0, 2) == 0);
        if (rd_cur < wcount && $urandom_range(0, 3) != 0) rd_cur++;
      end
      step(we, 8'($urandom), rd_cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
